// File: rtl/sfr_pkg.sv
// rtl/sfr_pkg.sv - shared constants for the adder and subtractor SFRs
package sfr_pkg;

  localparam int SFR_SIZE  = 32;
  localparam int SFR_CNT_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/add_sfr.sv
// rtl/add_sfr.sv - accumulating adder SFR with single add and N-times run
module add_sfr
  import sfr_pkg::*;
#(
  parameter int SIZE  = SFR_SIZE,
  parameter int CNT_W = SFR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             add,
  input  logic             start,
  input  logic [SIZE-1:0]  D,
  input  logic [SIZE-1:0]  A,
  input  logic [CNT_W-1:0] N,
  output logic [SIZE-1:0]  Q,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [SIZE-1:0]  a_lat;
  logic [SIZE-1:0]  operand;
  logic [SIZE:0]    sum;

  // One shared adder: the live addend in IDLE, the latched one during a run.
  always_comb begin
    operand = (state == ST_RUN) ? a_lat : A;
    sum     = {1'b0, Q} + {1'b0, operand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      a_lat <= '0;
      Q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        Q     <= D;
        ovf   <= 1'b0;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          a_lat <= A;
          count <= N;
          if (N == '0) begin
            done <= 1'b1;
          end else begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end else if (add) begin
          Q   <= sum[SIZE-1:0];
          ovf <= ovf | sum[SIZE];
        end
      end else begin
        Q     <= sum[SIZE-1:0];
        ovf   <= ovf | sum[SIZE];
        count <= count - 1'b1;
        if (count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sfr.sv
// tb/tb_add_sfr.sv - directed self-checking bench for add_sfr
module tb_add_sfr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld, add, start;
  logic [7:0] D, A;
  logic [3:0] N;
  logic [7:0] Q;
  logic       busy, done, ovf;

  int checks   = 0;
  int failures = 0;

  add_sfr #(.SIZE(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .add(add), .start(start),
    .D(D), .A(A), .N(N), .Q(Q), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic eb,
                         input logic ed, input logic eo);
    chk({tag, ".Q"}, Q, eq);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".done"}, done, ed);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  initial begin
    rst_n = 1'b0; ld = 0; add = 0; start = 0; D = 0; A = 0; N = 0;
    #12;
    chk_all("reset", 8'd0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // Basic run: 10 + 4*3
    ld = 1; D = 8'd10; step(); ld = 0;
    chk_all("ld10", 8'd10, 0, 0, 0);
    start = 1; A = 8'd3; N = 4'd4; step(); start = 0;
    chk_all("run.e0", 8'd10, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all($sformatf("run.e%0d", i), 8'(10 + 3 * i), i < 4, i == 4, 0);
    end
    step();
    chk_all("run.after", 8'd22, 0, 0, 0);

    // Overflow and sticky ovf
    ld = 1; D = 8'd250; step(); ld = 0;
    add = 1; A = 8'd10; step();
    chk_all("ovf.add10", 8'd4, 0, 0, 1);
    A = 8'd1; step(); add = 0;
    chk_all("ovf.add1", 8'd5, 0, 0, 1);
    ld = 1; D = 8'd0; step(); ld = 0;
    chk_all("ovf.clr", 8'd0, 0, 0, 0);

    // Abort a run with ld
    start = 1; A = 8'd1; N = 4'd8; step(); start = 0;
    step(); step(); step();
    chk_all("abort.pre", 8'd3, 1, 0, 0);
    ld = 1; D = 8'd99; step(); ld = 0;
    chk_all("abort.ld", 8'd99, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("abort.hold%0d", i), 8'd99, 0, 0, 0);
    end

    // Zero count
    start = 1; A = 8'd5; N = 4'd0; step(); start = 0;
    chk_all("n0.pulse", 8'd99, 0, 1, 0);
    step();
    chk_all("n0.after", 8'd99, 0, 0, 0);

    // ld beats start
    ld = 1; start = 1; D = 8'd7; A = 8'd1; N = 4'd5; step(); ld = 0; start = 0;
    chk_all("prio.ld", 8'd7, 0, 0, 0);
    step();
    chk_all("prio.after", 8'd7, 0, 0, 0);

    // Latched operands, add ignored in RUN
    ld = 1; D = 8'd0; step(); ld = 0;
    start = 1; A = 8'd2; N = 4'd3; step(); start = 0;
    A = 8'd9; N = 4'd15; add = 1; step(); add = 0;
    chk_all("stab.e1", 8'd2, 1, 0, 0);
    step();
    chk_all("stab.e2", 8'd4, 1, 0, 0);
    step();
    chk_all("stab.e3", 8'd6, 0, 1, 0);
    step();
    chk_all("stab.after", 8'd6, 0, 0, 0);

    // Asynchronous reset mid-run
    ld = 1; D = 8'd255; step(); ld = 0;
    add = 1; A = 8'd1; step(); add = 0;
    chk_all("rst.ovfset", 8'd0, 0, 0, 1);
    start = 1; A = 8'd1; N = 4'd5; step(); start = 0;
    step();
    chk_all("rst.pre", 8'd1, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst.async", 8'd0, 0, 0, 0);
    #1 rst_n = 1'b1;
    step();
    chk_all("rst.after", 8'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
